// File: rtl/jt12_amp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt12_amp_pkg
// Description : Shared types and default widths for the jt12 output amplifier
//               (channel state machine encoding, product width, output range).
// Revision    : 1.0 - initial release
// ============================================================================
package jt12_amp_pkg;

    // Default widths of the amplifier datapath
    localparam int DEF_IW   = 14;   // input sample width, signed
    localparam int DEF_OW   = 16;   // output sample width, signed
    localparam int DEF_CH   = 2;    // channel count
    localparam int DEF_GW   = 8;    // gain width, unsigned
    localparam int DEF_FRAC = 4;    // gain fractional bits
    localparam int DEF_STEP = 1;    // max gain change per sample

    // Signed product of an IW sample and a zero-extended GW gain
    localparam int PW   = DEF_IW + DEF_GW + 1;
    localparam int OMAX = (1 << (DEF_OW - 1)) - 1;
    localparam int OMIN = -(1 << (DEF_OW - 1));

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : jt12_amp_pkg
`default_nettype wire

// File: rtl/jt12_sat.sv
`default_nettype none
// ============================================================================
// Module      : jt12_sat
// Description : Combinational symmetric saturation of a signed IN_W value to
//               a signed OUT_W value, with an overflow flag when clamping.
// Ports       : i_din   - signed input value
//               o_dout  - saturated signed output
//               o_ovf   - high when i_din was outside the OUT_W range
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_sat
    import jt12_amp_pkg::*;
#(
    parameter int IN_W  = PW,
    parameter int OUT_W = DEF_OW
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout,
    output logic                    o_ovf
);

    generate
        if (IN_W > OUT_W) begin : g_narrow
            localparam logic [OUT_W-1:0] c_MAX = {1'b0, {(OUT_W-1){1'b1}}};
            localparam logic [OUT_W-1:0] c_MIN = {1'b1, {(OUT_W-1){1'b0}}};

            // The value fits only when every bit from the output sign bit
            // upward is a copy of the input sign.
            logic [IN_W-OUT_W:0] w_top;
            logic                w_ovf;

            assign w_top  = i_din[IN_W-1:OUT_W-1];
            assign w_ovf  = !((&w_top) || (~|w_top));
            assign o_ovf  = w_ovf;
            assign o_dout = w_ovf ? (i_din[IN_W-1] ? c_MIN : c_MAX)
                                  : i_din[OUT_W-1:0];
        end else if (IN_W == OUT_W) begin : g_equal
            assign o_dout = i_din;
            assign o_ovf  = 1'b0;
        end else begin : g_wide
            assign o_dout = {{(OUT_W-IN_W){i_din[IN_W-1]}}, i_din};
            assign o_ovf  = 1'b0;
        end
    endgenerate

endmodule : jt12_sat
`default_nettype wire

// File: rtl/jt12_amp_ramp.sv
`default_nettype none
// ============================================================================
// Module      : jt12_amp_ramp
// Description : Multi-channel output amplifier. On each accepted sample strobe
//               the input frame is latched, the applied gain ramps by at most
//               STEP toward the target, and one shared multiplier scales each
//               channel in turn. Results saturate to OW bits and are published
//               together with a one-cycle o_post_valid pulse, CH+2 cycles after
//               the strobe.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_sample      - new input frame strobe
//               i_pre         - packed signed inputs, channel k at [k*IW +: IW]
//               i_gain        - target gain (FRAC fractional bits)
//               i_mute        - forces the target gain to zero
//               i_clip_clr    - clears all sticky clip flags
//               o_post        - packed signed outputs, same packing as i_pre
//               o_post_valid  - one-cycle pulse when o_post updates
//               o_busy        - frame in progress
//               o_clip        - sticky per-channel clip flags
//               o_gain_cur    - gain currently applied
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_amp_ramp
    import jt12_amp_pkg::*;
#(
    parameter int IW   = DEF_IW,
    parameter int OW   = DEF_OW,
    parameter int CH   = DEF_CH,
    parameter int GW   = DEF_GW,
    parameter int FRAC = DEF_FRAC,
    parameter int STEP = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sample,
    input  logic [CH*IW-1:0]  i_pre,
    input  logic [GW-1:0]     i_gain,
    input  logic              i_mute,
    input  logic              i_clip_clr,
    output logic [CH*OW-1:0]  o_post,
    output logic              o_post_valid,
    output logic              o_busy,
    output logic [CH-1:0]     o_clip,
    output logic [GW-1:0]     o_gain_cur
);

    localparam int            c_PW   = IW + GW + 1;
    // Index runs 0..CH-1 through the multiplier, then CH+1 marks publish
    localparam int            c_IXW  = $clog2(CH + 2);
    localparam logic [GW-1:0] c_STEP = GW'(STEP);

    state_t                  r_state;
    logic [c_IXW-1:0]        r_idx;
    logic [CH*IW-1:0]        r_buf;
    logic [GW-1:0]           r_gain_cur;
    logic signed [c_PW-1:0]  r_prod;
    logic                    r_prod_vld;
    logic [c_IXW-1:0]        r_prod_ch;
    logic [CH*OW-1:0]        r_shadow;
    logic [CH*OW-1:0]        r_post;
    logic                    r_post_valid;
    logic                    r_busy;
    logic [CH-1:0]           r_clip;

    logic [IW-1:0]           w_sel;
    logic signed [c_PW-1:0]  w_mul_a;
    logic signed [c_PW-1:0]  w_mul_b;
    logic signed [c_PW-1:0]  w_prod;
    logic signed [c_PW-1:0]  w_shift;
    logic signed [OW-1:0]    w_sat;
    logic                    w_ovf;
    logic [CH-1:0]           w_clip_set;
    logic [GW-1:0]           w_tgt;
    logic [GW-1:0]           w_diff_up;
    logic [GW-1:0]           w_diff_dn;
    logic [GW-1:0]           w_ramp;

    // ---------------------------------------------------------------- ramp
    assign w_tgt     = i_mute ? '0 : i_gain;
    assign w_diff_up = w_tgt - r_gain_cur;
    assign w_diff_dn = r_gain_cur - w_tgt;

    // Steps are only taken when the distance exceeds STEP, so the result
    // can neither overshoot the target nor wrap around.
    always_comb begin
        w_ramp = w_tgt;
        if (STEP != 0) begin
            if ((w_tgt > r_gain_cur) && (w_diff_up > c_STEP)) begin
                w_ramp = r_gain_cur + c_STEP;
            end else if ((w_tgt < r_gain_cur) && (w_diff_dn > c_STEP)) begin
                w_ramp = r_gain_cur - c_STEP;
            end
        end
    end

    // ---------------------------------------------------- shared multiplier
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_idx == c_IXW'(k)) begin
                w_sel = r_buf[k*IW +: IW];
            end
        end
    end

    // Gain is zero-extended so it multiplies as a non-negative value
    assign w_mul_a = {{(GW+1){w_sel[IW-1]}}, w_sel};
    assign w_mul_b = {{IW{1'b0}}, 1'b0, r_gain_cur};
    assign w_prod  = w_mul_a * w_mul_b;

    // Arithmetic shift rounds toward minus infinity
    assign w_shift = r_prod >>> FRAC;

    jt12_sat #(
        .IN_W  (c_PW),
        .OUT_W (OW)
    ) u_sat (
        .i_din  (w_shift),
        .o_dout (w_sat),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_clip_set = '0;
        for (int k = 0; k < CH; k++) begin
            w_clip_set[k] = r_prod_vld && w_ovf && (r_prod_ch == c_IXW'(k));
        end
    end

    // ------------------------------------------------------------ sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_buf        <= '0;
            r_gain_cur   <= '0;
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_prod_ch    <= '0;
            r_shadow     <= '0;
            r_post       <= '0;
            r_post_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_clip       <= '0;
        end else begin
            // A clamp in the same cycle as a clear leaves the flag set
            r_clip       <= (r_clip & ~{CH{i_clip_clr}}) | w_clip_set;
            r_post_valid <= 1'b0;
            r_prod_vld   <= 1'b0;

            for (int k = 0; k < CH; k++) begin
                if (r_prod_vld && (r_prod_ch == c_IXW'(k))) begin
                    r_shadow[k*OW +: OW] <= w_sat;
                end
            end

            case (r_state)
                IDLE: begin
                    if (i_sample) begin
                        r_buf      <= i_pre;
                        r_gain_cur <= w_ramp;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (r_idx < c_IXW'(CH)) begin
                        r_prod     <= w_prod;
                        r_prod_ch  <= r_idx;
                        r_prod_vld <= 1'b1;
                    end
                    if (r_idx == c_IXW'(CH + 1)) begin
                        r_post       <= r_shadow;
                        r_post_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_idx        <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_idx <= r_idx + c_IXW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_post       = r_post;
    assign o_post_valid = r_post_valid;
    assign o_busy       = r_busy;
    assign o_clip       = r_clip;
    assign o_gain_cur   = r_gain_cur;

endmodule : jt12_amp_ramp
`default_nettype wire

// File: tb/tb_jt12_amp_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt12_amp_ramp
// Description : Directed self-checking bench for jt12_amp_ramp. Instance 0
//               applies gain immediately (STEP=0); instance 1 ramps (STEP=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_amp_ramp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0 = 1'b0;
    logic        s1 = 1'b0;
    logic [27:0] pre = '0;
    logic [7:0]  gain = '0;
    logic        mute = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] post0, post1;
    logic        pv0, pv1, busy0, busy1;
    logic [1:0]  clip0, clip1;
    logic [7:0]  gc0, gc1;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    jt12_amp_ramp #(.STEP(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_sample(s0), .i_pre(pre), .i_gain(gain),
        .i_mute(mute), .i_clip_clr(clr), .o_post(post0), .o_post_valid(pv0),
        .o_busy(busy0), .o_clip(clip0), .o_gain_cur(gc0)
    );

    jt12_amp_ramp #(.STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_sample(s1), .i_pre(pre), .i_gain(gain),
        .i_mute(mute), .i_clip_clr(clr), .o_post(post1), .o_post_valid(pv1),
        .o_busy(busy1), .o_clip(clip1), .o_gain_cur(gc1)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ch_val(input logic [31:0] p, input int k);
        logic signed [15:0] v;
        v = p[k*16 +: 16];
        return int'(v);
    endfunction

    task automatic set_pre(input int p0, input int p1);
        logic [13:0] t0, t1;
        t0 = p0[13:0];
        t1 = p1[13:0];
        pre = {t1, t0};
    endtask

    // One frame on the selected instance; lat = -1 if o_post_valid never came
    task automatic do_frame(input bit sel, input int p0, input int p1,
                            input logic [7:0] g, input logic m,
                            output int lat, output logic bsy);
        @(negedge clk);
        set_pre(p0, p1);
        gain = g;
        mute = m;
        if (sel) s1 = 1'b1; else s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0;
        s1 = 1'b0;
        bsy = sel ? busy1 : busy0;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? pv1 : pv0) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic bsy;
        int   npv;

        // ------------------------------------------------------------ reset
        repeat (3) @(negedge clk);
        chk("rst_post0", post0, 0);
        chk("rst_pv0", pv0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_gain1", gc1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_clip0", clip0, 0);

        // ------------------------------------------------------------ unity
        do_frame(0, 1000, -1000, 8'd16, 1'b0, lat, bsy);
        chk("unity_busy_c1", bsy, 1);
        chk("unity_lat", lat, 4);
        chk("unity_ch0", ch_val(post0, 0), 1000);
        chk("unity_ch1", ch_val(post0, 1), -1000);
        chk("unity_clip", clip0, 0);
        chk("unity_busy_end", busy0, 0);
        chk("unity_gain", gc0, 16);
        @(posedge clk);
        #1;
        chk("unity_pv_width", pv0, 0);
        chk("unity_hold_ch0", ch_val(post0, 0), 1000);

        // ------------------------------------------------------- saturation
        do_frame(0, 8191, -8192, 8'd255, 1'b0, lat, bsy);
        chk("sat_lat", lat, 4);
        chk("sat_ch0", ch_val(post0, 0), 32767);
        chk("sat_ch1", ch_val(post0, 1), -32768);
        chk("sat_clip", clip0, 2'b11);
        chk("sat_gain", gc0, 255);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_clip", clip0, 0);
        @(negedge clk);
        clr = 1'b0;
        do_frame(0, 0, 0, 8'd16, 1'b0, lat, bsy);
        chk("zero_ch0", ch_val(post0, 0), 0);
        chk("zero_ch1", ch_val(post0, 1), 0);
        chk("zero_clip", clip0, 0);

        // ------------------------------------------------------- truncation
        do_frame(0, -3, 3, 8'd8, 1'b0, lat, bsy);
        chk("trunc_neg", ch_val(post0, 0), -2);
        chk("trunc_pos", ch_val(post0, 1), 1);

        // ---------------------------------------------------------- overrun
        @(negedge clk);
        set_pre(100, 200);
        gain = 8'd16;
        s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0;
        @(negedge clk);
        set_pre(300, 400);
        gain = 8'd32;
        s0 = 1'b1;
        @(negedge clk);
        s0 = 1'b0;
        npv = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (pv0 === 1'b1) npv++;
        end
        chk("ovr_npv", npv, 1);
        chk("ovr_ch0", ch_val(post0, 0), 100);
        chk("ovr_ch1", ch_val(post0, 1), 200);
        chk("ovr_gain", gc0, 16);

        // -------------------------------------------------------------- ramp
        for (int i = 0; i < 16; i++) begin
            do_frame(1, 160, 0, 8'd16, 1'b0, lat, bsy);
        end
        chk("ramp_up16", gc1, 16);
        for (int i = 1; i <= 4; i++) begin
            do_frame(1, 160, -5, 8'd20, 1'b0, lat, bsy);
            chk("ramp_gain", gc1, 16 + i);
            chk("ramp_ch0", ch_val(post1, 0), 160 + 10 * i);
        end
        chk("ramp_lat", lat, 4);
        for (int i = 19; i >= 0; i--) begin
            do_frame(1, 160, -5, 8'd20, 1'b1, lat, bsy);
            chk("mute_gain", gc1, i);
        end
        do_frame(1, 160, -5, 8'd20, 1'b1, lat, bsy);
        chk("mute_floor", gc1, 0);
        chk("mute_ch0", ch_val(post1, 0), 0);
        chk("mute_ch1", ch_val(post1, 1), 0);

        // ------------------------------------------------------- async reset
        do_frame(1, 160, 0, 8'd16, 1'b0, lat, bsy);
        chk("pre_rst_ch0", ch_val(post1, 0), 10);
        @(negedge clk);
        set_pre(160, 0);
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", busy1, 1);
        rst = 1'b1;
        #1;
        chk("arst_post1", post1, 0);
        chk("arst_post0", post0, 0);
        chk("arst_busy1", busy1, 0);
        chk("arst_pv1", pv1, 0);
        chk("arst_gain1", gc1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        npv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (pv1 === 1'b1) npv++;
        end
        chk("arst_no_pv", npv, 0);
        do_frame(1, 160, 0, 8'd16, 1'b0, lat, bsy);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_gain", gc1, 1);
        chk("post_rst_ch0", ch_val(post1, 0), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule : tb_jt12_amp_ramp
`default_nettype wire

// File: doc/jt12_amp_ramp.md
Name: jt12_amp_ramp

Overview:
- Parametrised multi-channel output amplifier for the FM/PSG mix path.
- Applies one fine-grained unsigned fixed-point gain to CH signed channels, with per-sample gain ramping (no zipper noise) and symmetric saturation.
- Per-channel sticky clip flags.
- One shared multiplier, time-multiplexed across channels after each sample strobe; sits between the channel mixer and the DAC/I2S serialiser.

Parameters:
- IW, 14: input sample width, signed.
- OW, 16: output sample width, signed.
- CH, 2: channel count; 2 = stereo, left is channel 0.
- GW, 8: gain width, unsigned.
- FRAC, 4: gain fractional bits; unity gain = 2^FRAC = 16.
- STEP, 1: maximum gain change per sample; 0 = gain applied immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample  in  1  one-cycle strobe, new input frame valid
- pre  in  CH*IW  packed signed inputs; channel k = bits [k*IW +: IW]
- gain  in  GW  target gain, unsigned, FRAC fractional bits
- mute  in  1  forces the target gain to 0; the ramp still applies
- clip_clr  in  1  clears all clip flags
- post  out  CH*OW  packed signed outputs, same packing as pre
- post_valid  out  1  one-cycle pulse, post frame updated
- busy  out  1  channel processing in progress
- clip  out  CH  sticky per-channel saturation flags
- gain_cur  out  GW  gain currently applied

Behaviour:
- Reset (async, active-high) clears post, post_valid, busy, clip, gain_cur and the internal channel index; state returns to IDLE.
- Reset mid-frame abandons the frame. post stays 0 and no post_valid pulse is issued.
- States: IDLE and RUN.
- IDLE, sample=1 at cycle 0:
  - latch all of pre into the frame buffer;
  - gain_cur <= ramp(gain_cur, tgt), where tgt = mute ? 0 : gain;
  - go to RUN with idx=0; busy=1 from cycle 1.
- ramp():
  - if |tgt - gain_cur| <= STEP, or STEP=0: result = tgt;
  - otherwise gain_cur ± STEP toward tgt.
  - The updated gain applies to the frame just latched.
  - The gain never overshoots and never wraps.
- RUN pipeline:
  - Stage 1, cycles 1..CH: prod = buf[idx] * {1'b0, gain_cur}, signed width IW+GW+1; idx increments.
  - Stage 2, cycles 2..CH+1: scaled = prod >>> FRAC (arithmetic shift, truncate toward -inf), then saturate to OW.
  - Saturation: above 2^(OW-1)-1 clamps to the max; below -2^(OW-1) clamps to the min.
  - On a clamp, clip[ch] <= 1.
  - The result is written into a shadow register for that channel.
- Cycle CH+2:
  - all shadow registers copy into post simultaneously;
  - post_valid=1 for exactly one cycle;
  - busy=0; state returns to IDLE.
- post changes only on post_valid cycles and holds between frames.
- Total latency from sample to post_valid is CH+2 cycles.
- sample while busy=1, including cycle CH+2: the strobe is dropped.
  - Frame buffer and gain are unchanged.
  - The in-flight frame completes normally.
  - Callers must space strobes at least CH+3 cycles apart.
- clip_clr:
  - clears clip in the same cycle.
  - If a clamp occurs in the same cycle, the set wins.
- gain and mute are sampled only on accepted sample strobes; changes between strobes have no effect.
- Zero gain gives output 0 exactly, including negative inputs, since -x*0 = 0.

Decomposition:
- Package jt12_amp_pkg holds:
  - state enum (IDLE, RUN);
  - localparams PW = IW+GW+1, OMAX = 2^(OW-1)-1, OMIN = -2^(OW-1);
  - the default widths.
- Sub-module jt12_sat (parameters IN_W, OUT_W): combinational saturate of the shifted product, with an overflow flag output. It is reused by the FM accumulators.
- The ramp and sequencing stay in jt12_amp_ramp.

Test Plan:
- Unity gain: STEP=0, gain=16, pre ch0=+1000, ch1=-1000, sample pulse -> post_valid exactly 4 cycles later; post = +1000 / -1000; clip = 00.
- Saturation: gain=255, ch0=+8191, ch1=-8192 -> post ch0 = 32767, ch1 = -32768; clip = 11. Then clip_clr -> clip = 00. Then gain=16, pre=0 -> clip stays 00.
- Ramp: STEP=1, gain_cur=16, gain set to 20 -> four successive frames read gain_cur 17, 18, 19, 20. Then mute=1 -> gain_cur counts down 19, 18, ... to 0 with no undershoot.
- Truncation: gain=8 (x0.5), pre=-3 -> post = -2 (floor of -1.5). pre=+3 -> post = +1.
- Overrun: sample reasserted 2 cycles after an accepted strobe with different pre -> strobe ignored; single post_valid carrying the first frame's values; gain_cur advanced only once.
- Reset: assert rst asynchronously at cycle 2 of RUN -> outputs immediately 0; busy=0; no post_valid. The next sample after release processes normally from gain_cur=0.
